// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative signed multiply / divide unit that feeds the HI/LO registers of the
// multicycle CPU. The control FSM pulses mult_start or div_start for one cycle.
// The unit answers with a one-cycle done strobe when hi/lo carry a new result.
// A divide by zero returns a one-cycle div0 strobe instead of done.
//
// Multiply : radix-2 Booth, one iteration per clock, DATA_W iterations.
// Divide   : restoring division on operand magnitudes, DATA_W iterations.
//            Signs are fixed up in the FIN cycle. The quotient truncates
//            toward zero and the remainder takes the sign of the dividend.
//
// Optional feature macro: MDU_FAST_MULT_EN
//   When defined, MULT uses a combinational $signed(a)*$signed(b) and goes
//   straight to FIN, so done rises after edge 1. DIV is unaffected.
//
// Parameters
//   DATA_W      operand width; hi/lo are DATA_W bits each
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   mult_start  in   1       1-cycle pulse: begin signed a*b (wins over div)
//   div_start   in   1       1-cycle pulse: begin signed a/b
//   a           in   DATA_W  multiplicand / dividend
//   b           in   DATA_W  multiplier / divisor
//   hi          out  DATA_W  product upper half, or remainder
//   lo          out  DATA_W  product lower half, or quotient
//   busy        out  1       operation in progress
//   done        out  1       1-cycle strobe: hi/lo valid
//   div0        out  1       1-cycle strobe: divisor was zero
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div0
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DZ,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  // acc: Booth partial-product accumulator, or division partial remainder.
  // One extra bit absorbs the overflow of acc - M when M is the most
  // negative value, and the 2*divisor range of the shifted remainder.
  logic signed [DATA_W:0]  acc_q, acc_d;
  // m: sign-extended multiplicand, or zero-extended divisor magnitude.
  logic signed [DATA_W:0]  m_q, m_d;
  // qr: multiplier being shifted out, or dividend shifting into quotient.
  logic [DATA_W-1:0]       qr_q, qr_d;
  logic                    qm1_q, qm1_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic                    done_q, done_d;

  // Booth / restoring-division step signals
  logic signed [DATA_W:0]  booth_sum;
  logic [DATA_W:0]         div_shift;
  logic [DATA_W:0]         div_diff;
  logic                    div_ge;

  // Two's-complement magnitude. The most negative value maps onto itself,
  // which reads correctly as an unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  // Conditional two's-complement negation used by the sign fix-up.
  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

`ifdef MDU_FAST_MULT_EN
  logic signed [2*DATA_W-1:0] fast_prod;

  function automatic logic signed [2*DATA_W-1:0] sext2(input logic [DATA_W-1:0] v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  assign fast_prod = sext2(m_q[DATA_W-1:0]) * sext2(qr_q);
`endif

  // Booth recoding of {Q[0], Q[-1]}: 01 adds M, 10 subtracts M.
  always_comb begin
    booth_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  // Restoring step: shift the next dividend bit into the remainder, then try
  // to subtract the divisor. Keep the difference only if it did not go negative.
  assign div_shift = {acc_q[DATA_W-1:0], qr_q[DATA_W-1]};
  assign div_diff  = div_shift - $unsigned(m_q);
  assign div_ge    = (div_shift >= $unsigned(m_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    qr_d      = qr_q;
    qm1_d     = qm1_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mult_start) begin
          is_div_d = 1'b0;
          acc_d    = '0;
          m_d      = {a[DATA_W-1], a};
          qr_d     = b;
          qm1_d    = 1'b0;
`ifdef MDU_FAST_MULT_EN
          state_d  = S_FIN;
`else
          state_d  = S_MULT;
`endif
        end else if (div_start) begin
          if (b == '0) begin
            state_d = S_DZ;
          end else begin
            is_div_d  = 1'b1;
            acc_d     = '0;
            m_d       = {1'b0, magnitude(b)};
            qr_d      = magnitude(a);
            qm1_d     = 1'b0;
            neg_quo_d = a[DATA_W-1] ^ b[DATA_W-1];
            neg_rem_d = a[DATA_W-1];
            state_d   = S_DIV;
          end
        end
      end

      S_MULT: begin
        // Arithmetic shift right of {acc, qr, qm1} after the add/subtract.
        acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
        qr_d  = {booth_sum[0], qr_q[DATA_W-1:1]};
        qm1_d = qr_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIN;
        end
      end

      S_DIV: begin
        acc_d = div_ge ? div_diff : div_shift;
        qr_d  = {qr_q[DATA_W-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIN;
        end
      end

      S_DZ: begin
        state_d = S_IDLE;
      end

      S_FIN: begin
        if (is_div_q) begin
          lo_d = negate_if(qr_q, neg_quo_q);
          hi_d = negate_if(acc_q[DATA_W-1:0], neg_rem_q);
        end else begin
`ifdef MDU_FAST_MULT_EN
          hi_d = fast_prod[2*DATA_W-1:DATA_W];
          lo_d = fast_prod[DATA_W-1:0];
`else
          hi_d = acc_q[DATA_W-1:0];
          lo_d = qr_q;
`endif
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      qr_q      <= qr_d;
      qm1_q     <= qm1_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // busy covers the iteration cycles and the FIN cycle; it is low in the
  // done cycle and in the single div0 cycle.
  assign busy = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIN);
  assign div0 = (state_q == S_DZ);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

`ifdef MDU_FAST_MULT_EN
  localparam int MULT_LAT = 1;
  localparam int INJ_EDGE = 1;
`else
  localparam int MULT_LAT = 33;
  localparam int INJ_EDGE = 5;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int vectors;
  int miscompares;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div0       (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start pulse that is sampled on the next edge (edge 0).
  task automatic start_op(input bit is_mult, input logic [31:0] av, input logic [31:0] bv);
    a          = av;
    b          = bv;
    mult_start = is_mult;
    div_start  = !is_mult;
    tick();
    mult_start = 1'b0;
    div_start  = 1'b0;
  endtask

  // Count edges until done is seen; 100 marks a timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  // Run n edges and report how many times done was high.
  task automatic watch_no_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen++;
    end
  endtask

  int edges;
  int seen;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    a           = '0;
    b           = '0;

    // Reset state
    tick();
    tick();
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    check("rst div0", {31'b0, div0}, 32'h0);
    reset = 1'b1;
    tick();

    // Test 1: 7 * -3 = -21
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD);
    check("t1 busy after start", {31'b0, busy}, 32'h1);
    wait_done(edges);
    check("t1 latency", 32'(edges), 32'(MULT_LAT));
    check("t1 hi", hi, 32'hFFFF_FFFF);
    check("t1 lo", lo, 32'hFFFF_FFEB);
    check("t1 busy in done cycle", {31'b0, busy}, 32'h0);
    tick();
    check("t1 done one cycle", {31'b0, done}, 32'h0);
    check("t1 lo held", lo, 32'hFFFF_FFEB);

    // Test 2: -7 / 2 -> q=-3, r=-1
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    check("t2 busy after start", {31'b0, busy}, 32'h1);
    wait_done(edges);
    check("t2 latency", 32'(edges), 32'(DIV_LAT));
    check("t2 lo", lo, 32'hFFFF_FFFD);
    check("t2 hi", hi, 32'hFFFF_FFFF);
    tick();

    // Test 3: divide by zero
    start_op(1'b0, 32'd5, 32'd0);
    check("t3 div0", {31'b0, div0}, 32'h1);
    check("t3 busy", {31'b0, busy}, 32'h0);
    check("t3 done", {31'b0, done}, 32'h0);
    tick();
    check("t3 div0 one cycle", {31'b0, div0}, 32'h0);
    watch_no_done(40, seen);
    check("t3 no done", 32'(seen), 32'd0);
    check("t3 hi unchanged", hi, 32'hFFFF_FFFF);
    check("t3 lo unchanged", lo, 32'hFFFF_FFFD);

    // Test 4: overflow divide
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges);
    check("t4 latency", 32'(edges), 32'(DIV_LAT));
    check("t4 lo", lo, 32'h8000_0000);
    check("t4 hi", hi, 32'h0000_0000);
    tick();

    // Test 5 part 1: div_start while multiplying is ignored; a/b changes ignored
    start_op(1'b1, 32'hFFFF_FFFC, 32'd5);
    for (int i = 1; i < INJ_EDGE; i++) tick();
    a         = 32'd100;
    b         = 32'd7;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    wait_done(edges);
    check("t5a latency", 32'(edges + INJ_EDGE), 32'(MULT_LAT));
    check("t5a hi", hi, 32'hFFFF_FFFF);
    check("t5a lo", lo, 32'hFFFF_FFEC);
    tick();
    check("t5a no second done", {31'b0, done}, 32'h0);
    check("t5a busy idle", {31'b0, busy}, 32'h0);

    // Both starts high: multiply wins
    a          = 32'd3;
    b          = 32'd4;
    mult_start = 1'b1;
    div_start  = 1'b1;
    tick();
    mult_start = 1'b0;
    div_start  = 1'b0;
    wait_done(edges);
    check("prio latency", 32'(edges), 32'(MULT_LAT));
    check("prio lo", lo, 32'd12);
    check("prio hi", hi, 32'd0);
    tick();

    // Test 5 part 2: reset mid-divide
    start_op(1'b0, 32'd1000, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    check("t5b busy before reset", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("t5b hi", hi, 32'h0);
    check("t5b lo", lo, 32'h0);
    check("t5b busy", {31'b0, busy}, 32'h0);
    check("t5b done", {31'b0, done}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    watch_no_done(40, seen);
    check("t5b no done", 32'(seen), 32'd0);

    // Test 5 part 3: 6 * 6
    start_op(1'b1, 32'd6, 32'd6);
    wait_done(edges);
    check("t5c latency", 32'(edges), 32'(MULT_LAT));
    check("t5c lo", lo, 32'd36);
    check("t5c hi", hi, 32'd0);
    tick();

    // Test 6: 0x10000 * 0x10000 = 2^32
    start_op(1'b1, 32'h0001_0000, 32'h0001_0000);
    wait_done(edges);
    check("t6 latency", 32'(edges), 32'(MULT_LAT));
    check("t6 hi", hi, 32'h1);
    check("t6 lo", lo, 32'h0);
    tick();

    // Extra: most-negative multiplicand, -2^31 * -1 = 2^31
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges);
    check("mneg hi", hi, 32'h0);
    check("mneg lo", lo, 32'h8000_0000);
    tick();

    // Extra: 7 / -2 -> q=-3, r=1
    start_op(1'b0, 32'd7, 32'hFFFF_FFFE);
    wait_done(edges);
    check("div7 lo", lo, 32'hFFFF_FFFD);
    check("div7 hi", hi, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
